// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice sequenced LSB first, carry kept in a register.
// Latency: done pulses WIDTH edges after the accepting edge; minimum issue interval WIDTH+2 cycles.
// Backpressure: none; start is sampled only in IDLE and is dropped (not queued) while RUN/DONE.

module halfadder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic cout
);
  assign s    = x ^ y;
  assign cout = x & y;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_next;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             ha0_s, ha0_c, ha1_c, s_bit, c_next;

  halfadder ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(ha0_s), .cout(ha0_c));
  halfadder ha1 (.x(ha0_s),   .y(carry_q), .s(s_bit), .cout(ha1_c));

  assign c_next   = ha0_c | ha1_c;
  // Shift the new bit in from the top; the truncating form also covers WIDTH=1.
  assign acc_next = WIDTH'({s_bit, acc} >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      cnt     <= '0;
      carry_q <= 1'b0;
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          acc     <= acc_next;
          carry_q <= c_next;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= acc_next;
            cout  <= c_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): vector table, directed multi-cycle
// sequences, and random operands checked against plain integer addition.
module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] esum;
    logic       ecout;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One start pulse, then verify busy duration, done latency, result and pulse width.
  task automatic do_add(input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] esum, input logic ecout, input string tag);
    int lat, busy_cnt;
    a = aa; b = bb; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~aa; b = ~bb;
    lat = 0; busy_cnt = 0;
    while (done !== 1'b1 && lat < 30) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, 8);
    check({tag, " busy cycles"}, busy_cnt, 8);
    check({tag, " sum"}, sum, esum);
    check({tag, " cout"}, cout, ecout);
    tick();
    check({tag, " done width"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    logic [8:0] model;
    int pulses, last_t, t;

    vecs[0] = '{8'h5A, 8'h33, 8'h8D, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h7F, 8'hFF, 1'b0};

    // Reset has priority over a pending start.
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset sum", sum, 0);
      check("reset cout", cout, 0);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    check("idle after reset busy", busy, 0);

    for (int i = 0; i < 5; i++)
      do_add(vecs[i].va, vecs[i].vb, vecs[i].esum, vecs[i].ecout, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      model = 9'(int'(ra) + int'(rb));
      do_add(ra, rb, model[7:0], model[8], $sformatf("rand%0d", i));
    end

    // Requests during RUN/DONE are dropped; a still-high start is taken at E10.
    a = 8'h80; b = 8'h80; start = 1'b1;
    tick();
    a = 8'h11; b = 8'h22;
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (done === 1'b1) begin
        pulses++;
        check("ignore done edge", i, 8);
        check("ignore sum", sum, 8'h00);
        check("ignore cout", cout, 1);
      end
    end
    check("ignore done count", pulses, 1);
    check("ignore idle busy", busy, 0);
    tick();
    check("reaccept busy", busy, 1);
    start = 1'b0;
    t = 0;
    while (done !== 1'b1 && t < 30) begin tick(); t++; end
    check("reaccept latency", t, 8);
    check("reaccept sum", sum, 8'h33);
    check("reaccept cout", cout, 0);
    tick();

    // Reset mid-operation aborts without a done pulse.
    a = 8'h0F; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort sum", sum, 0);
    check("abort cout", cout, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check("abort no done", pulses, 0);
    check("abort sum held", sum, 0);
    do_add(8'h0F, 8'h01, 8'h10, 1'b0, "after abort");
    tick();

    // Start held high: one completion every WIDTH+2 cycles.
    a = 8'h01; b = 8'h02; start = 1'b1;
    pulses = 0; last_t = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) begin
        pulses++;
        if (last_t >= 0) check("b2b spacing", i - last_t, 10);
        last_t = i;
        check("b2b sum", sum, 8'h03);
        check("b2b cout", cout, 0);
      end
    end
    start = 1'b0;
    check("b2b pulses", pulses, 4);
    for (int i = 0; i < 12; i++) tick();
    check("b2b drained busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder sequencer. It adds two WIDTH-bit operands one bit per clock, LSB first. The only arithmetic is a single full-adder bit slice built from two `halfadder` instances plus an OR gate. The block captures the operands on a start request, runs the slice for WIDTH cycles while carrying between bits in a register, then presents the registered sum and carry-out with a one-cycle done pulse. It trades latency for area wherever a multi-bit add is needed only occasionally.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..32.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to add; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while the bit slice is being sequenced (RUN).
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle.
- sum  output  WIDTH  registered result (A+B) mod 2^WIDTH.
- cout  output  1  registered carry-out of bit WIDTH-1.

## Operation
- Bit slice, combinational, one instance:
  - ha0 = halfadder(a_bit, b_bit);
  - ha1 = halfadder(ha0.A, carry_q);
  - s_bit = ha1.A;
  - c_next = ha0.cout | ha1.cout.
- State registers:
  - state: IDLE, RUN or DONE.
  - a_sh, b_sh: WIDTH-bit operand shift registers.
  - acc: WIDTH-bit result shift register.
  - carry_q: 1-bit carry register.
  - cnt: bit counter, $clog2(WIDTH+1) bits.
  - sum, cout: output registers.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: load a_sh←a and b_sh←b, then clear carry_q and cnt, and go to RUN.
  - start=0: remain in IDLE.
- RUN (busy=1), on each edge:
  - a_bit=a_sh[0], b_bit=b_sh[0];
  - shift a_sh and b_sh right by one;
  - acc ← {s_bit, acc[WIDTH-1:1]};
  - carry_q ← c_next;
  - cnt ← cnt+1.
  - On the edge where cnt==WIDTH-1: load sum ← {s_bit, acc[WIDTH-1:1]} and cout ← c_next, then go to DONE.
- DONE:
  - done=1, busy=0, for exactly one cycle;
  - the next edge always returns to IDLE;
  - start is ignored in this state.
- Start while busy or in DONE has no effect: it is not queued and not latched.
- Changes on a and b after the accepting edge have no effect on the result.
- sum and cout change only on the DONE-entry edge and hold until the next completion.
- WIDTH=1: RUN lasts one cycle; the add is a plain full add with carry-in 0.

## Timing
- Reset (rst=1 at an edge) forces, on that edge:
  - state=IDLE;
  - busy=0, done=0;
  - sum=0, cout=0;
  - cnt=0, carry_q=0, acc=0.
- rst has priority over start.
- Let E0 be the edge that accepts start:
  - busy is high after E0 through after E(WIDTH-1), i.e. WIDTH cycles.
  - sum, cout and done update after E(WIDTH).
  - done falls after E(WIDTH+1).
- Start-to-done latency is WIDTH+... measured precisely: done is first high in the cycle following edge E(WIDTH), WIDTH edges after acceptance.
- Minimum issue interval is WIDTH+2 cycles. If start is held high continuously, it is re-accepted at E(WIDTH+2), the first IDLE cycle.
- Reset asserted during RUN or DONE aborts the operation:
  - no done pulse is produced;
  - sum and cout read 0;
  - the block is in IDLE and accepts start on the first edge with rst=0.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset: hold rst=1 for 2 cycles, with start=1, a=0xFF, b=0xFF -> busy=0, done=0, sum=0x00, cout=0 throughout, and no RUN entry.
- Basic add, WIDTH=8: a=0x5A, b=0x33, start pulse at E0 -> busy high for 8 cycles, then done single pulse after E8 with sum=0x8D, cout=0.
- Full carry ripple: a=0xFF, b=0x01 -> sum=0x00, cout=1; likewise 0xFF+0xFF -> sum=0xFE, cout=1.
- Ignored requests:
  - Setup: start a=0x80, b=0x80, then drive a=0x11, b=0x22 with start=1 during RUN and in the DONE cycle.
  - Required: sum=0x00, cout=1; done fires once; the second add (0x11+0x22 -> sum=0x33, cout=0) is accepted at E10 only if start is still high there.
- Reset mid-operation: start a=0x0F, b=0x01, then assert rst for one edge at E3 -> busy=0 next cycle, no done within 20 cycles, sum=0x00, cout=0. A fresh start then completes normally with 0x0F+0x01 -> 0x10.
- Back-to-back throughput: start held high for 40 cycles with constant a=0x01, b=0x02 -> done pulses exactly every 10 cycles, each with sum=0x03, cout=0.
